mem_unit: RTL

MEM_UNIT -- requirements
Module: mem_unit

---
 rtl/mem_unit_if.sv | 24 ++
 rtl/mem_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_unit_if.sv
// Request/response bus between the MEM stage and the memory controller.
// The MEM stage is the master; the memory controller is the slave.
interface mem_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_cnf;
    logic              rsp_valid;
    logic [31:0]       rsp_data;

    modport master (
        output req_valid, req_addr, req_wr, req_wdata, req_cnf,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_wr, req_wdata, req_cnf,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mem_unit.sv
// MEM pipeline stage: blocking loads, store buffer that drains in the background,
// load/store word-address hazard detection and misaligned-access trapping.
module mem_unit #(
    parameter int SB_DEPTH = 2,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] memaddr_i,
    input  logic              memwr_i,
    input  logic [1:0]        memcnf_i,
    input  logic              memsigned_i,
    input  logic              flush,
    output logic              mem_stall,
    output logic              out_valid,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              misalign_o,
    mem_unit_if.master        bus
);
    localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, LD_REQ, LD_WAIT, ST_REQ, ST_WAIT} state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [1:0]        cnf;
    } sb_ent_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        cnf;
        logic              sgn;
        logic [4:0]        wd;
        logic              wreg;
    } ld_t;

    state_e              state_q, state_d;
    ld_t                 ld_q, ld_d;
    logic                kill_q, kill_d;
    sb_ent_t             sb_q [SB_DEPTH];
    logic [SB_DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d, wreg_q, wreg_d, misalign_q, misalign_d;
    logic [4:0]          wd_q, wd_d;
    logic [31:0]         wdata_q, wdata_d;

    logic    misaligned, hazard, ld_busy, pop, push, ld_acc, alu_acc, mis_acc, accept;
    sb_ent_t head_ent;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] cnf,
                                           input logic sgn);
        case (cnf)
            2'd1:    return {{24{sgn & d[7]}}, d[7:0]};
            2'd2:    return {{16{sgn & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign head_ent = sb_q[head_q];

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        misaligned = (memcnf_i == 2'd2 && memaddr_i[0]) ||
                     (memcnf_i == 2'd3 && memaddr_i[1:0] != 2'b00);
        hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (vld_q[i] && sb_q[i].addr[ADDR_W-1:2] == memaddr_i[ADDR_W-1:2]) hazard = 1'b1;
        end
        ld_busy = (state_q == LD_REQ) || (state_q == LD_WAIT);
        pop     = (state_q == ST_WAIT) && bus.rsp_valid;
        alu_acc = in_valid && !ld_busy && memcnf_i == 2'd0;
        mis_acc = in_valid && !ld_busy && memcnf_i != 2'd0 && misaligned;
        // A full buffer still takes a store when the head retires in the same cycle.
        push    = in_valid && !ld_busy && memcnf_i != 2'd0 && !misaligned && memwr_i &&
                  (cnt_q != CNT_W'(SB_DEPTH) || pop);
        ld_acc  = in_valid && state_q == IDLE && memcnf_i != 2'd0 && !misaligned &&
                  !memwr_i && !hazard;
        accept    = alu_acc || mis_acc || push || ld_acc;
        mem_stall = rst && in_valid && !accept;
    end

    always_comb begin
        state_d     = state_q;
        ld_d        = ld_q;
        kill_d      = kill_q;
        vld_d       = vld_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        misalign_d  = 1'b0;
        wd_d        = '0;
        wreg_d      = 1'b0;
        wdata_d     = '0;

        if (ld_acc) begin
            ld_d   = '{addr: memaddr_i, cnf: memcnf_i, sgn: memsigned_i, wd: wd_i, wreg: wreg_i};
            kill_d = 1'b0;
        end
        if (alu_acc) begin
            out_valid_d = 1'b1;
            wd_d        = wd_i;
            wreg_d      = wreg_i;
            wdata_d     = wdata_i;
        end
        if (mis_acc || push) begin
            out_valid_d = 1'b1;
            misalign_d  = mis_acc;
            wd_d        = wd_i;
        end

        case (state_q)
            IDLE: begin
                if (ld_acc)               state_d = LD_REQ;
                else if (cnt_q != '0)     state_d = ST_REQ;
            end
            LD_REQ: begin
                if (bus.req_ready) begin
                    state_d = LD_WAIT;
                    kill_d  = flush;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            LD_WAIT: begin
                if (flush) kill_d = 1'b1;
                if (bus.rsp_valid) begin
                    state_d = IDLE;
                    if (!(kill_q || flush)) begin
                        out_valid_d = 1'b1;
                        wd_d        = ld_q.wd;
                        wreg_d      = ld_q.wreg;
                        wdata_d     = extend(bus.rsp_data, ld_q.cnf, ld_q.sgn);
                    end
                end
            end
            ST_REQ:  if (bus.req_ready) state_d = ST_WAIT;
            ST_WAIT: if (bus.rsp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = ptr_inc(head_q);
        end
        if (push) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = ptr_inc(tail_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ld_q        <= '0;
            kill_q      <= 1'b0;
            vld_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ld_q        <= ld_d;
            kill_q      <= kill_d;
            vld_q       <= vld_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            misalign_q  <= misalign_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
        end
    end

    // NOTE: buffer storage has no reset; vld_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) sb_q[tail_q] <= '{addr: memaddr_i, data: wdata_i, cnf: memcnf_i};
    end

    assign out_valid  = out_valid_q;
    assign wd_o       = wd_q;
    assign wreg_o     = wreg_q;
    assign wdata_o    = wdata_q;
    assign misalign_o = misalign_q;

    assign bus.req_valid = (state_q == LD_REQ) || (state_q == ST_REQ);
    assign bus.req_wr    = (state_q == ST_REQ);
    assign bus.req_addr  = (state_q == LD_REQ) ? ld_q.addr :
                           (state_q == ST_REQ) ? head_ent.addr : '0;
    assign bus.req_cnf   = (state_q == LD_REQ) ? ld_q.cnf :
                           (state_q == ST_REQ) ? head_ent.cnf : 2'd0;
    assign bus.req_wdata = (state_q == ST_REQ) ? head_ent.data : '0;
endmodule
